// File: rtl/scopes_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// scopes_seq_ctrl_if
//   Bundles the operand handshake, result handshake and status signals of
//   scopes_seq_ctrl.
//   master : operand source / result consumer
//            (drives in_valid, in_k, abort, out_ready)
//   slave  : the sequencer
//            (drives in_ready, out_valid, out_x, out_y, busy, step)
// ---------------------------------------------------------------------------
interface scopes_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_k;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             busy;
    logic [2:0]       step;

    modport master (
        output in_valid, in_k, abort, out_ready,
        input  in_ready, out_valid, out_x, out_y, busy, step
    );

    modport slave (
        input  in_valid, in_k, abort, out_ready,
        output in_ready, out_valid, out_x, out_y, busy, step
    );
endinterface

// File: rtl/scopes_seq_ctrl.sv
// ---------------------------------------------------------------------------
// scopes_seq_ctrl
//   Multi-cycle sequencer for the scoped x/y update chain. An operand k is
//   accepted through a valid/ready handshake, the chain is applied one step
//   per clock (S1..S7), and the final x/y pair is offered through a second
//   valid/ready handshake.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    scopes_seq_ctrl_if.slave:
//              in_valid/in_ready/in_k   operand handshake
//              out_valid/out_ready      result handshake
//              out_x/out_y              result (x/y registers)
//              abort                    synchronous abort (ignored in IDLE)
//              busy                     high while computing
//              step                     0 = IDLE/DONE, 1..7 = S1..S7
//
//   Optional macro SCOPES_SEQ_FAST_EN: replaces S1..S7 by a single COMPUTE
//   state that evaluates the whole chain in one cycle (step reads 7).
// ---------------------------------------------------------------------------
module scopes_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SEED_A = 11,
    parameter int unsigned SEED_B = 22,
    parameter int unsigned SEED_C = 33,
    parameter int unsigned SEED_D = 44,
    parameter int unsigned MUL_K  = 23,
    parameter int unsigned ADD_K  = 77
) (
    input  logic             clk,
    input  logic             rst_n,
    scopes_seq_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0] SA_W  = WIDTH'(SEED_A);
    localparam logic [WIDTH-1:0] SB_W  = WIDTH'(SEED_B);
    localparam logic [WIDTH-1:0] SC_W  = WIDTH'(SEED_C);
    localparam logic [WIDTH-1:0] SD_W  = WIDTH'(SEED_D);
    localparam logic [WIDTH-1:0] MUL_W = WIDTH'(MUL_K);
    localparam logic [WIDTH-1:0] ADD_W = WIDTH'(ADD_K);

    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, DONE, COMPUTE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q, y_q, x_d, y_d;
    logic [3:0]       k_q;
    logic [WIDTH-1:0] k_w;
    logic             out_valid_q, in_ready_q, busy_q;
    logic [2:0]       step_q;

    function automatic logic [WIDTH-1:0] f1(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        return ((a + b) ^ b) ^ a;
    endfunction

    function automatic logic [WIDTH-1:0] f2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        return a - b;
    endfunction

`ifdef SCOPES_SEQ_FAST_EN
    // Whole S1..S7 chain in one pass; returns {x, y}.
    function automatic logic [2*WIDTH-1:0] chain(input logic [WIDTH-1:0] k);
        logic [WIDTH-1:0] x, y;
        x = f1(SA_W, SB_W);
        y = f2(SC_W, SD_W);
        x = x + k * MUL_W;
        y = y ^ (-(ADD_W + k));
        x = x + k;
        x = f1(y, x);
        y = f2(y, x);
        return {x, y};
    endfunction
`endif

    assign k_w = {{(WIDTH-4){1'b0}}, k_q};

    // Value of x/y at the end of the current step.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (state_q)
            S1:      x_d = f1(SA_W, SB_W);
            S2:      y_d = f2(SC_W, SD_W);
            S3:      x_d = x_q + k_w * MUL_W;
            S4:      y_d = y_q ^ (-(ADD_W + k_w));
            S5:      x_d = x_q + k_w;
            S6:      x_d = f1(y_q, x_q);
            S7:      y_d = f2(y_q, x_q);
`ifdef SCOPES_SEQ_FAST_EN
            COMPUTE: {x_d, y_d} = chain(k_w);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            step_q      <= 3'd0;
        end else if (bus.abort && state_q != IDLE) begin
            // x/y keep whatever the last completed step wrote
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            step_q      <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        k_q        <= bus.in_k;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SCOPES_SEQ_FAST_EN
                        state_q    <= COMPUTE;
                        step_q     <= 3'd7;
`else
                        state_q    <= S1;
                        step_q     <= 3'd1;
`endif
                    end
                end
                S1, S2, S3, S4, S5, S6: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    state_q <= state_t'(state_q + 4'd1);
                    step_q  <= step_q + 3'd1;
                end
                S7, COMPUTE: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    step_q  <= 3'd0;
                end
                DONE: begin
                    // out_valid is raised one edge after entering DONE; the
                    // consumer is only honoured once it has seen out_valid.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;
    assign bus.busy      = busy_q;
    assign bus.step      = step_q;
endmodule

// File: tb/tb_scopes_seq_ctrl.sv
module tb_scopes_seq_ctrl;
`ifdef SCOPES_SEQ_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    scopes_seq_ctrl_if #(.WIDTH(16)) bus ();

    scopes_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [3:0] k);
        bus.in_k     = k;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge after the accept edge (edge 0).
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
`ifdef SCOPES_SEQ_FAST_EN
            if (n == 0) chk({tag, "_step"}, 32'(bus.step), 7);
`else
            if (n < 7) chk({tag, "_step"}, 32'(bus.step), n + 1);
`endif
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
    endtask

    task automatic result(input string tag, input logic [15:0] ex, input logic [15:0] ey);
        chk({tag, "_x"}, 32'(bus.out_x), 32'(ex));
        chk({tag, "_y"}, 32'(bus.out_y), 32'(ey));
    endtask

    task automatic consume(input string tag);
        tick();
        chk({tag, "_ovdrop"}, 32'(bus.out_valid), 0);
        chk({tag, "_irdy"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_k      = 4'd0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_irdy", 32'(bus.in_ready), 1);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_step", 32'(bus.step), 0);
        chk("rst_x", 32'(bus.out_x), 0);

        // k = 0, consumer always ready
        bus.out_ready = 1'b1;
        launch(4'd0);
        chk("k0_busy", 32'(bus.busy), 1);
        chk("k0_irdy", 32'(bus.in_ready), 0);
        wait_valid("k0");
        result("k0", 16'h00F8, 16'hFF4E);
        consume("k0");

        // k = 15
        launch(4'd15);
        wait_valid("k15");
        result("k15", 16'h0000, 16'h0051);
        consume("k15");

        // Reset in the middle of an operation
        launch(4'd3);
        repeat (3) tick();
`ifndef SCOPES_SEQ_FAST_EN
        chk("mid_step", 32'(bus.step), 4);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_irdy", 32'(bus.in_ready), 1);
        chk("arst_ov", 32'(bus.out_valid), 0);
        chk("arst_x", 32'(bus.out_x), 0);
        chk("arst_y", 32'(bus.out_y), 0);
        chk("arst_step", 32'(bus.step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // k = 5 with a stalled consumer and ignored operand offers
        bus.out_ready = 1'b0;
        launch(4'd5);
        bus.in_k     = 4'd9;
        bus.in_valid = 1'b1;
        wait_valid("k5");
        result("k5", 16'h01E0, 16'hFE7B);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            tick();
            chk("hold_ov", 32'(bus.out_valid), 1);
            chk("hold_irdy", 32'(bus.in_ready), 0);
            result("hold", 16'h01E0, 16'hFE7B);
        end
        // Consume and offer k = 0 together: offer must not be taken yet
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_k      = 4'd0;
        tick();
        chk("b2b_ov", 32'(bus.out_valid), 0);
        chk("b2b_irdy", 32'(bus.in_ready), 1);
        chk("b2b_busy", 32'(bus.busy), 0);
        tick();
        bus.in_valid = 1'b0;
        wait_valid("b2b");
        result("b2b", 16'h00F8, 16'hFF4E);
        consume("b2b");

        // Abort in S5
        launch(4'd7);
        repeat (4) tick();
`ifndef SCOPES_SEQ_FAST_EN
        chk("ab_step5", 32'(bus.step), 5);
`endif
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_irdy", 32'(bus.in_ready), 1);
        chk("ab_ov", 32'(bus.out_valid), 0);
        chk("ab_step", 32'(bus.step), 0);
        chk("ab_busy", 32'(bus.busy), 0);
`ifndef SCOPES_SEQ_FAST_EN
        result("ab_hold", 16'h00DD, 16'h0059);
`endif
        repeat (3) begin
            tick();
            chk("ab_noov", 32'(bus.out_valid), 0);
        end

        // k = 15 accepted while abort is high in IDLE
        bus.abort = 1'b1;
        launch(4'd15);
        bus.abort = 1'b0;
        wait_valid("ab15");
        result("ab15", 16'h0000, 16'h0051);
        consume("ab15");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scopes_seq_ctrl.md
Name: scopes_seq_ctrl

Overview:
- Multi-cycle sequencer for the scoped function/task datapath: the x/y update chain built from func_01, func_02, task_01, task_02 and block foo.
- Applies one datapath step per clock instead of one combinational cloud.
- Accepts a 4-bit operand `k` through a valid/ready handshake and returns the final x/y pair through a second valid/ready handshake.
- Sits between an operand source and a result consumer.

Parameters:
- WIDTH, 16, width of the x/y accumulators; all arithmetic is modulo 2^WIDTH.
- SEED_A, 11, first func_01 operand for step S1.
- SEED_B, 22, second func_01 operand for step S1.
- SEED_C, 33, minuend for step S2.
- SEED_D, 44, subtrahend for step S2.
- MUL_K, 23, multiplier applied to `k` in step S3.
- ADD_K, 77, addend applied to `k` in step S4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  high only in IDLE.
- in_k  in  4  operand k; latched on accept.
- abort  in  1  synchronous abort of the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_x  out  WIDTH  final x.
- out_y  out  WIDTH  final y.
- busy  out  1  high in S1..S7.
- step  out  3  current step index: 0 = IDLE/DONE, 1..7 = S1..S7.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - x, y, latched k, out_valid and busy all clear to 0.
  - in_ready goes to 1.
- Definitions: f1(a,b) = ((a+b) ^ b) ^ a; f2(a,b) = a - b. All arithmetic is WIDTH bits wide; k is zero-extended.
- States: IDLE, S1..S7, DONE.
- Transitions:
  - IDLE -> S1 when in_valid && in_ready; in_k is latched on that edge.
  - S1 -> S2 -> ... -> S7, one step per clock.
  - S7 -> DONE.
  - DONE -> IDLE when out_ready.
- Step updates (registered at the end of each step):
  - S1: x = f1(SEED_A, SEED_B).
  - S2: y = f2(SEED_C, SEED_D).
  - S3: x = x + k*MUL_K.
  - S4: y = y ^ (-(ADD_K + k)).
  - S5: x = x + k.
  - S6: x = f1(y, x).
  - S7: y = f2(y, x), using the x value written by S6.
- Latency:
  - The accept edge is edge 0.
  - out_valid rises after edge 8 (7 compute steps plus the DONE entry).
  - out_x/out_y equal the x/y registers and are stable while out_valid is high.
- Handshake rules:
  - in_valid while not IDLE is ignored; no buffering.
  - out_valid stays high until out_ready is sampled high. On that edge out_valid drops and the state returns to IDLE.
  - A new operand is accepted no earlier than the next edge (in_ready = 1 in IDLE, 0 in DONE).
  - out_ready while not DONE has no effect.
- abort:
  - Sampled each edge in any state other than IDLE: state goes to IDLE and out_valid to 0; x/y hold their current value.
  - abort has priority over out_ready in DONE.
  - abort in IDLE has no effect; any simultaneous operand accept proceeds.
- Simultaneous events: in DONE with out_ready high and in_valid high, the result is consumed and the operand is not accepted (in_ready was 0).
- Reset mid-operation clears all state immediately; no result is produced.

Optional Feature:
- Macro: SCOPES_SEQ_FAST_EN.
- Defined: S1..S7 collapse into a single COMPUTE state that evaluates the whole chain combinationally in one cycle.
  - out_valid rises after edge 2.
  - step reads 7 during COMPUTE.
  - All other behaviour is unchanged.
- Undefined: the 7-step sequence described above.

Test Plan:
- Reset while running at S4 -> next sample shows IDLE, in_ready = 1, out_valid = 0, out_x = out_y = 0.
- k = 0, out_ready held high -> out_valid after edge 8, out_x = 0x00F8, out_y = 0xFF4E; step reads 1..7 on successive cycles.
- k = 15 -> out_x = 0x0000, out_y = 0x0051.
- k = 5 with out_ready low for 5 cycles -> out_valid and out_x = 0x01E0, out_y = 0xFE7B held stable throughout; in_valid pulses during busy/DONE are ignored; after out_ready, a back-to-back k = 0 gives 0x00F8/0xFF4E.
- abort asserted in S5 -> IDLE on the next edge, no out_valid; a following k = 15 gives 0x0000/0x0051.
- SCOPES_SEQ_FAST_EN defined, k = 5 -> out_valid after edge 2, out_x = 0x01E0, out_y = 0xFE7B.
